// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - geometry, AXI constants and state type for the I-cache refill sequencer
package icache_pkg;

  localparam int SETS        = 512;
  localparam int SET_BITS    = 9;
  localparam int LINE_WORDS  = 8;
  localparam int WORD_BITS   = 3;
  localparam int BYTE_BITS   = 3;
  localparam int OFFSET_BITS = WORD_BITS + BYTE_BITS;
  localparam int TAG_BITS    = 64 - SET_BITS - OFFSET_BITS;
  localparam int TIMEOUT     = 256;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'd3;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    COMMIT
  } refill_state_e;

endpackage

// File: rtl/refill_timer.sv
// rtl/refill_timer.sv - handshake watchdog; fires after LIMIT consecutive cycles of run without kick
module refill_timer #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    expired = 1'b0;
    if (!run || kick) begin
      count_d = '0;
    end else if (count_q == W'(LIMIT - 1)) begin
      expired = 1'b1;
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - miss/refill sequencer: one AXI4 INCR line burst into the 2-way I-cache
// Optional watchdog abort on a hung slave: define ICACHE_REFILL_TIMEOUT_EN.
module icache_refill_ctrl
  import icache_pkg::*;
  #(parameter int TIMEOUT_CYCLES = TIMEOUT)
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   miss_req,
  input  logic [63:0]            miss_addr,
  input  logic                   lru_way,
  input  logic                   flush,
  output logic                   stall,
  output logic                   refill_done,
  output logic                   err,
  output logic                   m_arvalid,
  input  logic                   m_arready,
  output logic [63:0]            m_araddr,
  output logic [7:0]             m_arlen,
  output logic [2:0]             m_arsize,
  output logic [1:0]             m_arburst,
  input  logic                   m_rvalid,
  output logic                   m_rready,
  input  logic [63:0]            m_rdata,
  input  logic [1:0]             m_rresp,
  input  logic                   m_rlast,
  output logic                   fill_we,
  output logic [SET_BITS-1:0]    fill_set,
  output logic                   fill_way,
  output logic [WORD_BITS-1:0]   fill_word,
  output logic [63:0]            fill_data,
  output logic                   fill_tag_we,
  output logic [TAG_BITS:0]      fill_tag
);

  localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(LINE_WORDS - 1);
  localparam logic [7:0]           BURST_LEN = 8'(LINE_WORDS - 1);

  refill_state_e         state_q, state_d;
  logic [TAG_BITS-1:0]   tag_q, tag_d;
  logic [SET_BITS-1:0]   set_q, set_d;
  logic                  way_q, way_d;
  logic [WORD_BITS-1:0]  cnt_q, cnt_d;
  logic                  abort_q, abort_d;
  logic                  err_q, err_d;
  logic                  timeout;
  logic                  unused_offset;

  // The byte/word offset of the miss never matters: the whole line is fetched.
  assign unused_offset = ^miss_addr[OFFSET_BITS-1:0];

`ifdef ICACHE_REFILL_TIMEOUT_EN
  // Kick/run are decoded from registered state so the timer never loops through the output logic.
  refill_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_refill_timer (
    .clk     (clk),
    .rst     (reset),
    .run     ((state_q == ADDR) || (state_q == DATA)),
    .kick    (((state_q == ADDR) && m_arready) || ((state_q == DATA) && m_rvalid)),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    set_d       = set_q;
    way_d       = way_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    err_d       = err_q;
    stall       = 1'b0;
    refill_done = 1'b0;
    m_arvalid   = 1'b0;
    m_araddr    = '0;
    m_arlen     = '0;
    m_arsize    = '0;
    m_arburst   = '0;
    m_rready    = 1'b0;
    fill_we     = 1'b0;
    fill_word   = cnt_q;
    fill_data   = '0;
    fill_tag_we = 1'b0;
    fill_tag    = '0;

    case (state_q)
      IDLE: begin
        if (miss_req) begin
          tag_d   = miss_addr[63 -: TAG_BITS];
          set_d   = miss_addr[OFFSET_BITS +: SET_BITS];
          way_d   = lru_way;
          err_d   = 1'b0;
          abort_d = 1'b0;
          state_d = ADDR;
        end
      end

      ADDR: begin
        stall     = 1'b1;
        m_arvalid = 1'b1;
        m_araddr  = {tag_q, set_q, {OFFSET_BITS{1'b0}}};
        m_arlen   = BURST_LEN;
        m_arsize  = SIZE_8B;
        m_arburst = BURST_INCR;
        // A flushed request still has to complete its handshake; it is only marked dead.
        if (flush) begin
          abort_d = 1'b1;
        end
        if (m_arready) begin
          fill_tag_we = 1'b1;
          fill_tag    = {1'b0, tag_q};
          cnt_d       = '0;
          state_d     = DATA;
        end
        if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      DATA: begin
        stall    = 1'b1;
        m_rready = 1'b1;
        if (flush) begin
          abort_d = 1'b1;
        end
        if (m_rvalid) begin
          fill_we   = ~(abort_q | flush);
          fill_data = m_rdata;
          cnt_d     = cnt_q + 1'b1;
          if (m_rresp != RESP_OKAY) begin
            err_d = 1'b1;
          end
          // Our own beat count decides the end of the burst; rlast is only cross-checked.
          if (m_rlast != (cnt_q == LAST_WORD)) begin
            err_d = 1'b1;
          end
          if (cnt_q == LAST_WORD) begin
            state_d = COMMIT;
          end
        end
        if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      COMMIT: begin
        fill_tag_we = 1'b1;
        fill_tag    = {~(err_q | abort_q), tag_q};
        refill_done = ~(err_q | abort_q);
        abort_d     = 1'b0;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign err      = err_q;
  assign fill_set = set_q;
  assign fill_way = way_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tag_q   <= '0;
      set_q   <= '0;
      way_q   <= 1'b0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      set_q   <= set_d;
      way_q   <= way_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

endmodule
